// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM link blocks: sample format and accumulator sizing.
package pdm_pkg;

   localparam int unsigned SAMPLE_W = 10;
   localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 10'd1023;

   typedef logic [SAMPLE_W-1:0] sample_t;

   // Accumulator width for a second-order CIC with unity input: 2*log2(decim) + 1.
   function automatic int unsigned acc_w(input int unsigned decim);
      return 2 * $clog2(decim) + 1;
   endfunction

endpackage

// File: rtl/pdm_comb_stage.sv
// One CIC comb section: y <= x - x_prev on enable, with the delay register updated alongside.
module pdm_comb_stage #(
   parameter int unsigned W = 13
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   logic [W-1:0] prev_q, prev_d;
   logic [W-1:0] y_q, y_d;

   always_comb begin
      prev_d = prev_q;
      y_d    = y_q;
      if (enable) begin
         y_d    = x - prev_q;
         prev_d = x;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
         y_q    <= '0;
      end else begin
         prev_q <= prev_d;
         y_q    <= y_d;
      end
   end

   assign y = y_q;

endmodule

// File: rtl/pdm_demod.sv
// PDM-to-PCM decoder: 2nd-order CIC decimator plus scale/saturate to 10-bit unsigned.
// Optional PDM_DEMOD_CLIP_EN adds a registered clip flag alongside dout.
module pdm_demod
   import pdm_pkg::*;
#(
   parameter int unsigned DECIM = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                din,
   output logic [SAMPLE_W-1:0] dout,
   output logic                valid
`ifdef PDM_DEMOD_CLIP_EN
   ,
   output logic                clip
`endif
);

   localparam int unsigned LOG2D = $clog2(DECIM);
   localparam int unsigned ACC_W = acc_w(DECIM);
   localparam int unsigned SHIFT = 2 * LOG2D - SAMPLE_W;
   localparam logic [LOG2D-1:0] CNT_MAX = LOG2D'(DECIM - 1);
   localparam logic [ACC_W-1:0] MAX_W = ACC_W'(SAMPLE_MAX);

   logic [ACC_W-1:0] i1_q, i1_d;
   logic [ACC_W-1:0] i2_q, i2_d;
   logic [ACC_W-1:0] s_q, s_d;
   logic [LOG2D-1:0] cnt_q, cnt_d;
   logic [2:0]       tick_q, tick_d;
   logic [1:0]       warm_q, warm_d;
   sample_t          dout_q, dout_d;
   logic             valid_q, valid_d;
   logic [ACC_W-1:0] c1, c2;
   logic [ACC_W-1:0] scaled;
   logic             over;
   logic             tick;

   assign tick = (cnt_q == CNT_MAX);

   // Integrators wrap modulo 2^ACC_W; the comb differences undo the wrap.
   always_comb begin
      i1_d  = i1_q + ACC_W'(din);
      i2_d  = i2_q + i1_d;
      cnt_d = cnt_q + 1'b1;
      s_d   = tick ? i2_d : s_q;
      // tick_q[0] enables comb 1, [1] enables comb 2, [2] loads the output stage.
      tick_d = {tick_q[1:0], tick};
   end

   pdm_comb_stage #(
      .W (ACC_W)
   ) u_comb1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (tick_q[0]),
      .x      (s_q),
      .y      (c1)
   );

   pdm_comb_stage #(
      .W (ACC_W)
   ) u_comb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (tick_q[1]),
      .x      (c1),
      .y      (c2)
   );

   assign scaled = c2 >> SHIFT;
   assign over   = (scaled > MAX_W);

   // First two results only prime the comb delays and are never emitted.
   always_comb begin
      warm_d  = warm_q;
      valid_d = 1'b0;
      dout_d  = dout_q;
      if (tick_q[2]) begin
         if (warm_q == 2'd2) begin
            valid_d = 1'b1;
            dout_d  = over ? SAMPLE_MAX : scaled[SAMPLE_W-1:0];
         end else begin
            warm_d = warm_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i1_q    <= '0;
         i2_q    <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         tick_q  <= '0;
         warm_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         warm_q  <= warm_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;

`ifdef PDM_DEMOD_CLIP_EN
   logic clip_q, clip_d;

   always_comb begin
      clip_d = clip_q;
      if (valid_d) begin
         clip_d = over;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip_q <= 1'b0;
      end else begin
         clip_q <= clip_d;
      end
   end

   assign clip = clip_q;
`endif

endmodule

// File: tb/tb_pdm_demod.sv
// Bench for pdm_demod: triangular-FIR reference model feeding a scoreboard of expected samples.
module tb_pdm_demod;

   localparam int DECIM  = 64;
   localparam int HIST_N = 32768;

   typedef struct {
      int   at_edge;
      int   dout;
      logic clip;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       din;
   logic [9:0] dout;
   logic       valid;
`ifdef PDM_DEMOD_CLIP_EN
   logic       clip;
`endif

   pdm_demod #(
      .DECIM (DECIM)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .dout  (dout),
      .valid (valid)
`ifdef PDM_DEMOD_CLIP_EN
      ,
      .clip  (clip)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;
   bit   hist [HIST_N];
   exp_t sb [$];
   int   exp_dout = 0;
   logic exp_clip = 1'b0;
   int   last_v   = 0;
   int   first_v  = 0;
   bit   collect  = 0;
   int   lb_sum   = 0;
   int   lb_n     = 0;

   task automatic check_val(input string tag, input int obs, input int exp_v, input int tol);
      int diff;
      n_checks++;
      diff = obs - exp_v;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (tol %0d) at edge %0d",
                  tag, obs, exp_v, tol, edge_n);
      end
   endtask

   // CIC2 with decimation D equals a length-(2D-1) triangular FIR sampled every D bits.
   function automatic exp_t model(input int t);
      exp_t e;
      int   sum;
      int   w;
      sum = 0;
      for (int j = 0; j < 2 * DECIM - 1; j++) begin
         w = (j < DECIM) ? j + 1 : 2 * DECIM - 1 - j;
         if (t - j >= 1) sum += w * int'(hist[t - j]);
      end
      e.at_edge = t + 3;
      e.dout    = ((sum >> 2) > 1023) ? 1023 : (sum >> 2);
      e.clip    = ((sum >> 2) > 1023);
      return e;
   endfunction

   task automatic cyc(input logic b);
      exp_t e;
      bit   exp_valid;
      @(negedge clk);
      din = b;
      @(posedge clk);
      edge_n++;
      if (edge_n < HIST_N) hist[edge_n] = b;
      if ((edge_n % DECIM == 0) && (edge_n >= 3 * DECIM)) sb.push_back(model(edge_n));
      #1;
      exp_valid = (sb.size() > 0) && (sb[0].at_edge == edge_n);
      check_val("valid", int'(valid), int'(exp_valid), 0);
      if (exp_valid) begin
         e        = sb.pop_front();
         exp_dout = e.dout;
         exp_clip = e.clip;
      end
      if (valid) begin
         if (first_v == 0) first_v = edge_n;
         if (last_v > 0) check_val("spacing", edge_n - last_v, DECIM, 0);
         last_v = edge_n;
         if (collect) begin
            lb_sum += int'(dout);
            lb_n++;
         end
      end
      check_val("dout", int'(dout), exp_dout, 0);
`ifdef PDM_DEMOD_CLIP_EN
      check_val("clip", int'(clip), int'(exp_clip), 0);
`endif
   endtask

   task automatic clear_model();
      for (int i = 0; i < HIST_N; i++) hist[i] = 1'b0;
      sb.delete();
      edge_n   = 0;
      exp_dout = 0;
      exp_clip = 1'b0;
      last_v   = 0;
      first_v  = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_dout"}, int'(dout), 0, 0);
      check_val({tag, "_valid"}, int'(valid), 0, 0);
`ifdef PDM_DEMOD_CLIP_EN
      check_val({tag, "_clip"}, int'(clip), 0, 0);
`endif
   endtask

   // First-order sigma-delta stand-in for the pdm modulator.
   task automatic loopback(input int x);
      logic [10:0] acc;
      int          avg;
      acc     = '0;
      lb_sum  = 0;
      lb_n    = 0;
      collect = 0;
      for (int k = 0; k < 19 * DECIM; k++) begin
         if (k == 3 * DECIM) collect = 1;
         acc = {1'b0, acc[9:0]} + 11'(x);
         cyc(acc[10]);
      end
      collect = 0;
      check_val("lb_count", lb_n, 16, 0);
      avg = (lb_n > 0) ? (lb_sum + lb_n / 2) / lb_n : -1000;
      check_val("lb_level", avg, x, 2);
   endtask

   initial begin
      int guard;
      rst_n = 1'b0;
      din   = 1'b0;
      clear_model();
      repeat (5) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;

      repeat (4 * DECIM) cyc(1'b0);
      check_val("first_valid", first_v, 3 * DECIM + 3, 0);

      repeat (6 * DECIM) cyc(1'b1);
      check_val("ones", int'(dout), 1023, 0);

      for (int k = 0; k < 6 * DECIM; k++) cyc((k % 2) == 0);
      check_val("alt", int'(dout), 512, 0);

      loopback(300);
      loopback(0);
      loopback(1);
      loopback(512);
      loopback(1022);
      loopback(1023);

      repeat (10000) cyc(1'($urandom_range(0, 1)));

      repeat (3 * DECIM) cyc(1'b1);
      guard = 0;
      while ((edge_n % DECIM != 37) && (guard < 2 * DECIM)) begin
         cyc(1'b1);
         guard++;
      end
      check_val("cnt37_reached", edge_n % DECIM, 37, 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      clear_model();
      rst_n = 1'b1;
      repeat (4 * DECIM) cyc(1'b1);
      check_val("first_valid_after_rst", first_v, 3 * DECIM + 3, 0);
      check_val("ones_after_rst", int'(dout), 1023, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pdm_demod.md
# pdm_demod

PDM-to-PCM decoder: turns the 1-bit density stream produced by the `pdm` modulator back into 10-bit unsigned samples. It uses a second-order CIC decimator followed by a scaling/saturation stage. It is the receiving end of the `pdm` link and serves two purposes: bench loop-back checking of the synth voice path, and ingesting external PDM sources (e.g. MEMS microphone) into the same 10-bit sample domain used by `Amp` and `sine_gen`.

## Interface
Parameters:
- `DECIM`, 64: decimation ratio. Power of two, 32..1024. One output sample every `DECIM` clocks.

Ports:
- `clk` in, 1: system clock (50 MHz on Nexys A7). One PDM bit is consumed per clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `din` in, 1: PDM bit stream, synchronous to `clk`.
- `dout` out, 10: reconstructed unsigned sample, 0..1023. Held between updates.
- `valid` out, 1: one-cycle strobe, high in the cycle `dout` takes a new value.
- `clip` out, 1: present only with `PDM_DEMOD_CLIP_EN`; see Configuration.

## Operation
- Derived constants:
  - `LOG2D = log2(DECIM)`
  - `ACC_W = 2*LOG2D + 1` (all accumulators)
  - `SHIFT = 2*LOG2D - 10`
- Integrators, every clock, modular `ACC_W`-bit arithmetic:
  - `i1 <= i1 + din`
  - `i2 <= i2 + i1_next`
  - Overflow wraps silently. Two's-complement wrap is correct by CIC construction; no saturation in the integrators.
- Decimation counter `cnt` (`LOG2D` bits) increments every clock and wraps at `DECIM-1`.
- Tick: the clock edge where `cnt == DECIM-1` is tick T.
  - At T: `s <= i2_next`, i.e. `s` includes that cycle's bit.
- Comb pipeline, modular `ACC_W` bits:
  - T+1: `c1 <= s - s_prev`, then `s_prev <= s`.
  - T+2: `c2 <= c1 - c1_prev`, then `c1_prev <= c1`.
  - T+3: `dout <= min(c2 >> SHIFT, 1023)`, and `valid <= 1`.
- Full-scale behaviour: `c2` spans 0..`DECIM^2`. All-ones input gives `DECIM^2 >> SHIFT = 1024`, which saturates to 1023.
- Warm-up: the first two ticks after reset only prime the comb delays.
  - A 2-bit `warm` counter suppresses `valid` and holds `dout` at 0 until the third tick's result.
  - The first `valid` arrives at cycle `3*DECIM + 3` after reset release (cnt starts at 0).
- Reset mid-operation clears everything, including `warm`. Warm-up restarts from scratch; no partial frame is ever emitted.

## Timing
- Reset values: all of the following are 0:
  - `dout`, `valid`, `clip`
  - `cnt`, `i1`, `i2`, `s`, `s_prev`, `c1`, `c1_prev`, `c2`, `warm`
- Latency from tick edge to `valid`: exactly 3 clocks. `valid` pulses exactly once per `DECIM` clocks in steady state and is never high two cycles in a row.
- Group delay of the filter is `DECIM - 1` input bits, plus the 3-cycle pipeline.
- No back-pressure: the consumer must sample `dout` while `valid` is high, or any time before the next `valid`.
- `din` is not synchronised internally. External asynchronous sources need a 2-FF synchroniser upstream.

## Configuration
- `PDM_DEMOD_CLIP_EN` defined:
  - The `clip` port exists.
  - `clip` is registered alongside `dout`, high with `valid` iff `(c2 >> SHIFT) > 1023`, and held until the next `valid`.
- `PDM_DEMOD_CLIP_EN` undefined:
  - No `clip` port and no compare logic.
  - Saturation of `dout` is identical in both builds.

## Structure
- Package `pdm_pkg` holds:
  - `SAMPLE_W = 10`, `SAMPLE_MAX = 10'd1023`
  - the `sample_t` typedef (`logic [9:0]`)
  - the `acc_w(decim)` constant function
  - All PDM blocks use this package.
- One sub-module, `pdm_comb_stage`: a single registered differentiator with `enable` and delay register. It is instantiated twice.
- Integrators, counter, warm-up and output stage stay inline.

## Test plan
- Reset: hold `rst_n` low for 5 clocks, then release with `din = 0` → `dout = 0`, `valid = 0` until cycle 195 (`DECIM = 64`); first `valid` at 195 with `dout = 0`.
- Constant `din = 1` → every `valid` after warm-up gives `dout = 1023`; `clip = 1` with the macro.
- Alternating `din` 1,0,1,0 → `dout = 512` on every valid; `clip = 0`.
- Loop-back through `pdm` with `din = 300`, `rst = 0` → steady-state `dout` within 300±2. Sweep 0, 1, 512, 1022, 1023 with the same ±2 tolerance (1023 may read 1023 only).
- Valid cadence: 10,000 clocks of random `din` → `valid` spacing is exactly 64 clocks and never back-to-back.
- Reset mid-frame: assert `rst_n` at `cnt = 37` → all outputs are 0 on the asynchronous edge; after release, the next `valid` again arrives at cycle 195.
